// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch slice.
//   fetch_state_t   - fetch FSM encoding (FETCH=0, HALT=1, FAULT=2)
//   fetch_entry_t   - one buffered fetch result {pc, instr}
//   FETCH_BUF_DEPTH - number of entries in the fetch buffer
//   FETCH_INSTR_W   - instruction field width carried in fetch_entry_t
package fetch_pkg;

  localparam int FETCH_BUF_DEPTH = 2;
  localparam int FETCH_INSTR_W   = 32;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]              pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_controller_buffer.sv
// fetch_buffer: two-entry FIFO of fetch_entry_t between fetch and decode.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   push_i          - write push_entry_i at the clock edge
//   pop_i           - retire the head entry at the clock edge
//   flush_i         - discard all entries (overrides push and pop)
//   push_entry_i    - entry to write
//   count_o         - number of valid entries (0..2)
//   head_o          - oldest entry (meaningful only when count_o != 0)
// The caller never pushes when full without popping in the same cycle,
// and never pops when empty.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t push_entry_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t mem_q [FETCH_BUF_DEPTH];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_i) wr_ptr_d = ~wr_ptr_q;
      if (pop_i)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < FETCH_BUF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      // When full with a simultaneous pop, wr_ptr equals rd_ptr: the head is
      // read combinationally this cycle and overwritten at the edge.
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: sequential instruction fetch with a 2-entry output buffer.
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   imem_addr, imem_read_en     - word address / read enable to instruction memory
//   imem_instruction            - asynchronous read data from instruction memory
//   redirect_valid, redirect_pc - branch/jump target (highest priority, flushes)
//   halt_req                    - stop fetching (enter HALT)
//   out_valid/out_ready         - decode handshake: an entry transfers on a cycle
//                                 where both are high; out_valid stays high and
//                                 out_pc/out_instr stay stable until transfer
//                                 or flush
//   out_instr, out_pc           - head entry of the buffer
//   fault, state_o              - status (fault = state FAULT)
//   perf_fetched, perf_flushes  - event counters
// Configuration: define FETCH_PERF_EN to build the perf counters; otherwise
// the perf ports are tied to zero.
// The buffered instruction field is FETCH_INSTR_W bits wide; WIDTH is
// expected to match it.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int          WIDTH        = 32,
  parameter int          SIZE         = 1024,
  parameter int          ADDRESS_SIZE = 10,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [ADDRESS_SIZE-1:0] imem_addr,
  output logic                    imem_read_en,
  input  logic [WIDTH-1:0]        imem_instruction,
  input  logic                    redirect_valid,
  input  logic [31:0]             redirect_pc,
  input  logic                    halt_req,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_instr,
  output logic [31:0]             out_pc,
  output logic                    fault,
  output logic [1:0]              state_o,
  output logic [31:0]             perf_fetched,
  output logic [31:0]             perf_flushes
);

  // One extra bit so SIZE*4 == 2^32 would still compare correctly.
  localparam logic [32:0] PC_LIMIT = 33'(SIZE) * 33'd4;

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic         fault_q;

  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic         pop;
  logic         pc_in_range;
  logic         redirect_ok;
  logic         fetch_fire;

  assign out_valid   = (count != 2'd0);
  assign pop         = out_valid && out_ready;
  assign pc_in_range = ({1'b0, pc_q} < PC_LIMIT);
  assign redirect_ok = (redirect_pc[1:0] == 2'b00) && ({1'b0, redirect_pc} < PC_LIMIT);

  // A full buffer may still accept a fetch when the head leaves this cycle.
  // rst gates the fire so imem_read_en is low for the whole reset.
  assign fetch_fire = !rst && (state_q == FETCH) && !redirect_valid && !halt_req &&
                      pc_in_range && ((count < 2'(FETCH_BUF_DEPTH)) || pop);

  assign push_entry.pc    = pc_q;
  assign push_entry.instr = FETCH_INSTR_W'(imem_instruction);

  fetch_buffer u_buffer (
    .clk          (clk),
    .rst          (rst),
    .push_i       (fetch_fire),
    .pop_i        (pop),
    .flush_i      (redirect_valid),
    .push_entry_i (push_entry),
    .count_o      (count),
    .head_o       (head)
  );

  // FSM and program counter. Redirect wins in every state; otherwise a fault
  // on an out-of-range PC takes precedence over a halt request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else if (redirect_valid) begin
      if (redirect_ok) begin
        pc_q    <= redirect_pc;
        state_q <= FETCH;
        fault_q <= 1'b0;
      end else begin
        state_q <= FAULT;
        fault_q <= 1'b1;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (!pc_in_range) begin
            state_q <= FAULT;
            fault_q <= 1'b1;
          end else if (halt_req) begin
            state_q <= HALT;
          end else if (fetch_fire) begin
            pc_q <= pc_q + 32'd4;
          end
        end
        HALT:    state_q <= HALT;
        FAULT:   state_q <= FAULT;
        default: begin
          state_q <= FAULT;
          fault_q <= 1'b1;
        end
      endcase
    end
  end

  assign imem_addr    = pc_q[ADDRESS_SIZE+1:2];
  assign imem_read_en = fetch_fire;
  assign out_pc       = head.pc;
  assign out_instr    = WIDTH'(head.instr);
  assign fault        = fault_q;
  assign state_o      = state_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_flushes_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= 32'd0;
      perf_flushes_q <= 32'd0;
    end else begin
      if (fetch_fire)     perf_fetched_q <= perf_fetched_q + 32'd1;
      if (redirect_valid) perf_flushes_q <= perf_flushes_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushes = perf_flushes_q;
`else
  assign perf_fetched = 32'd0;
  assign perf_flushes = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [9:0]  imem_addr;
  logic        imem_read_en;
  logic [31:0] imem_instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [1:0]  state_o;
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushes;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] imem [1024];

  fetch_controller dut (
    .clk              (clk),
    .rst              (rst),
    .imem_addr        (imem_addr),
    .imem_read_en     (imem_read_en),
    .imem_instruction (imem_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .halt_req         (halt_req),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instr        (out_instr),
    .out_pc           (out_pc),
    .fault            (fault),
    .state_o          (state_o),
    .perf_fetched     (perf_fetched),
    .perf_flushes     (perf_flushes)
  );

  assign imem_instruction = imem[imem_addr];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memory contents: word 0 is a NOP, every other word tags its index
  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    if (pc == 32'h0) return 32'h00000013;
    return 32'hC000_0000 | (pc >> 2);
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt_req       = 1'b0;
    out_ready      = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0; halt_req = 1'b0; out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL rst_fault: got %b want 0", fault); end
    n_cmp++; if (state_o !== 2'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", state_o); end
    n_cmp++; if (imem_read_en !== 1'b0) begin n_bad++; $display("FAIL rst_read_en: got %b want 0", imem_read_en); end
    n_cmp++; if (perf_fetched !== 32'd0) begin n_bad++; $display("FAIL rst_perf_fetched: got %0d want 0", perf_fetched); end
    rst = 1'b0;
    #1;
    n_cmp++; if (imem_read_en !== 1'b1) begin n_bad++; $display("FAIL rel_read_en: got %b want 1", imem_read_en); end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rel_out_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_pc !== 32'h0) begin n_bad++; $display("FAIL rel_out_pc: got %h want 0", out_pc); end
    n_cmp++; if (out_instr !== 32'h00000013) begin n_bad++; $display("FAIL rel_out_instr: got %h want 00000013", out_instr); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++; if (out_pc !== 32'(4 * i)) begin n_bad++; $display("FAIL stream_pc%0d: got %h want %h", i, out_pc, 32'(4 * i)); end
      n_cmp++; if (out_instr !== exp_instr(32'(4 * i))) begin n_bad++; $display("FAIL stream_instr%0d: got %h want %h", i, out_instr, exp_instr(32'(4 * i))); end
    end
    n_cmp++; if (perf_fetched !== (PERF ? 32'd4 : 32'd0)) begin n_bad++; $display("FAIL perf_fetched: got %0d want %0d", perf_fetched, PERF ? 4 : 0); end
  endtask

  task automatic test_backpressure();
    logic [31:0] want;
    do_reset();
    repeat (5) tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_pc !== 32'h0) begin n_bad++; $display("FAIL bp_head_pc: got %h want 0", out_pc); end
    n_cmp++; if (imem_read_en !== 1'b0) begin n_bad++; $display("FAIL bp_read_en: got %b want 0", imem_read_en); end
    n_cmp++; if (imem_addr !== 10'd2) begin n_bad++; $display("FAIL bp_pc_hold: got addr %0d want 2", imem_addr); end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (imem_read_en !== 1'b1) begin n_bad++; $display("FAIL bp_fire_on_pop: got %b want 1", imem_read_en); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      want = 32'(4 * i);
      n_cmp++; if (out_pc !== want) begin n_bad++; $display("FAIL bp_seq%0d: got %h want %h", i, out_pc, want); end
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    repeat (2) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL redir_flush: got %b want 0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL redir_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_pc !== 32'h40) begin n_bad++; $display("FAIL redir_pc: got %h want 40", out_pc); end
    n_cmp++; if (out_instr !== exp_instr(32'h40)) begin n_bad++; $display("FAIL redir_instr: got %h want %h", out_instr, exp_instr(32'h40)); end
    n_cmp++; if (perf_flushes !== (PERF ? 32'd1 : 32'd0)) begin n_bad++; $display("FAIL perf_flushes: got %0d want %0d", perf_flushes, PERF ? 1 : 0); end
  endtask

  task automatic test_fault_misaligned();
    do_reset();
    out_ready = 1'b1;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    tick();
    redirect_valid = 1'b0;
    repeat (2) tick();
    n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL mis_fault: got %b want 1", fault); end
    n_cmp++; if (state_o !== 2'd2) begin n_bad++; $display("FAIL mis_state: got %0d want 2", state_o); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mis_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (imem_read_en !== 1'b0) begin n_bad++; $display("FAIL mis_read_en: got %b want 0", imem_read_en); end
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (state_o !== 2'd0 || fault !== 1'b0) begin n_bad++; $display("FAIL mis_recover: got state %0d fault %b want 0 0", state_o, fault); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_bad++; $display("FAIL mis_refetch: got valid %b pc %h want 1 0", out_valid, out_pc); end
  endtask

  task automatic test_fault_range();
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_cmp++; if (out_pc !== 32'hFFC) begin n_bad++; $display("FAIL rng_last_pc: got %h want ffc", out_pc); end
    n_cmp++; if (out_instr !== exp_instr(32'hFFC)) begin n_bad++; $display("FAIL rng_last_instr: got %h want %h", out_instr, exp_instr(32'hFFC)); end
    tick();
    n_cmp++; if (fault !== 1'b1 || state_o !== 2'd2) begin n_bad++; $display("FAIL rng_fault: got fault %b state %0d want 1 2", fault, state_o); end
    n_cmp++; if (imem_read_en !== 1'b0) begin n_bad++; $display("FAIL rng_read_en: got %b want 0", imem_read_en); end
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'hFFC) begin n_bad++; $display("FAIL rng_kept: got valid %b pc %h want 1 ffc", out_valid, out_pc); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0 || state_o !== 2'd2) begin n_bad++; $display("FAIL rng_drain: got valid %b state %0d want 0 2", out_valid, state_o); end
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_cmp++; if (state_o !== 2'd0 || out_pc !== 32'h0 || out_valid !== 1'b1) begin n_bad++; $display("FAIL rng_recover: got state %0d pc %h valid %b want 0 0 1", state_o, out_pc, out_valid); end
  endtask

  task automatic test_halt();
    do_reset();
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    n_cmp++; if (state_o !== 2'd1) begin n_bad++; $display("FAIL halt_state: got %0d want 1", state_o); end
    n_cmp++; if (imem_read_en !== 1'b0) begin n_bad++; $display("FAIL halt_read_en: got %b want 0", imem_read_en); end
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_bad++; $display("FAIL halt_head: got valid %b pc %h want 1 0", out_valid, out_pc); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0 || state_o !== 2'd1) begin n_bad++; $display("FAIL halt_drain: got valid %b state %0d want 0 1", out_valid, state_o); end
    tick();
    n_cmp++; if (state_o !== 2'd1) begin n_bad++; $display("FAIL halt_stays: got %0d want 1", state_o); end
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (state_o !== 2'd0) begin n_bad++; $display("FAIL halt_resume_state: got %0d want 0", state_o); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h10) begin n_bad++; $display("FAIL halt_resume_pc: got valid %b pc %h want 1 10", out_valid, out_pc); end
    n_cmp++; if (out_instr !== exp_instr(32'h10)) begin n_bad++; $display("FAIL halt_resume_instr: got %h want %h", out_instr, exp_instr(32'h10)); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (2) tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_async_clear: got %b want 0", out_valid); end
    n_cmp++; if (imem_addr !== 10'd0) begin n_bad++; $display("FAIL mid_pc_reset: got addr %0d want 0", imem_addr); end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_bad++; $display("FAIL mid_restart: got valid %b pc %h want 1 0", out_valid, out_pc); end
    tick();
    n_cmp++; if (out_pc !== 32'h4) begin n_bad++; $display("FAIL mid_restart_next: got %h want 4", out_pc); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = 32'hC000_0000 | 32'(i);
    imem[0] = 32'h00000013;
    test_reset();
    test_backpressure();
    test_redirect_full();
    test_fault_misaligned();
    test_fault_range();
    test_halt();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 32: instruction width in bits.
REQ-002 SHALL have parameter SIZE, default 1024: number of instruction memory words.
REQ-003 SHALL have parameter ADDRESS_SIZE, default 10: word-address width, equal to log2(SIZE).
REQ-004 SHALL have parameter RESET_PC, default 32'h0: byte PC loaded at reset.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port imem_addr, output, ADDRESS_SIZE bits: word address to instruction memory.
REQ-008 SHALL have port imem_read_en, output, 1 bit: instruction memory read enable.
REQ-009 SHALL have port imem_instruction, input, WIDTH bits: asynchronous read data from instruction memory.
REQ-010 SHALL have ports redirect_valid, input, 1 bit, and redirect_pc, input, 32 bits: branch/jump target request.
REQ-011 SHALL have port halt_req, input, 1 bit: stop fetching.
REQ-012 SHALL have ports out_valid, output, 1 bit; out_ready, input, 1 bit; out_instr, output, WIDTH bits; out_pc, output, 32 bits: decode-side handshake.
REQ-013 SHALL have ports fault, output, 1 bit, and state_o, output, 2 bits: status.
REQ-014 SHALL have ports perf_fetched, output, 32 bits, and perf_flushes, output, 32 bits.

Function
REQ-015 SHALL implement FSM states FETCH=0, HALT=1, FAULT=2.
REQ-016 SHALL hold a 2-entry FIFO of {pc, instr}; out_valid = FIFO non-empty; out_instr/out_pc = head entry; pop when out_valid && out_ready.
REQ-017 SHALL drive imem_addr = pc[ADDRESS_SIZE+1:2] at all times and imem_read_en = fetch_fire only.
REQ-018 SHALL define fetch_fire = state==FETCH && !redirect_valid && !halt_req && pc < SIZE*4 && (count<2 || pop).
REQ-019 SHALL, on fetch_fire, push {pc, imem_instruction} at the clock edge and set pc <= pc+4; a push and a pop in the same cycle both take effect.
REQ-020 SHALL, in FETCH with pc >= SIZE*4 and no redirect, enter FAULT with no push, leaving buffered entries intact.
REQ-021 SHALL give redirect_valid top priority in every state: flush the FIFO (a same-cycle pop is discarded), no fetch that cycle, and increment perf_flushes.
REQ-022 SHALL, on a redirect with redirect_pc[1:0]==0 and redirect_pc < SIZE*4, set pc <= redirect_pc and state <= FETCH; the target is fetched the next cycle.
REQ-023 SHALL, on any other redirect, keep pc and enter FAULT.
REQ-024 SHALL, on halt_req without redirect, enter HALT from FETCH; HALT leaves only via a valid redirect, and FIFO draining continues while halted.
REQ-025 SHALL hold fault = (state==FAULT); FAULT leaves only via a valid redirect.
REQ-026 SHALL make perf_fetched +1 per fetch_fire; both counters wrap modulo 2^32.

Reset
REQ-027 SHALL, while rst=1, asynchronously force pc=RESET_PC, state=FETCH, FIFO empty, out_valid=0, fault=0, perf counters=0, imem_read_en=0.
REQ-028 SHALL fetch RESET_PC on the first edge after rst deasserts, with out_valid=1 one cycle later; reset mid-operation discards all buffered entries.

Configuration
REQ-029 SHALL, with macro FETCH_PERF_EN defined, implement the perf_fetched and perf_flushes counters.
REQ-030 SHALL, without FETCH_PERF_EN, keep both perf ports but tie them to constant 0, with no counter flops.

Structure
REQ-031 SHALL place the state enum (fetch_state_t), the entry struct (fetch_entry_t: pc, instr) and FETCH_BUF_DEPTH=2 in package fetch_pkg.
REQ-032 SHALL implement the FIFO as sub-module fetch_buffer (push, pop, flush, count, head), with the FSM and PC in fetch_controller.

Verification
REQ-033 SHALL test reset release with imem[0]=32'h00000013 and out_ready=1: cycle 1 gives out_valid=1, out_pc=0, out_instr=32'h00000013; then PCs 4, 8, 12 follow every cycle.
REQ-034 SHALL test out_ready=0 for 5 cycles: the FIFO fills to 2, imem_read_en=0 afterwards, pc holds at 8, and no entry is lost or duplicated after out_ready rises.
REQ-035 SHALL test redirect_pc=32'h40 while the FIFO is full: out_valid=0 next cycle, out_pc=32'h40 the cycle after, perf_flushes=1.
REQ-036 SHALL test redirect_pc=32'h42 and, separately, pc reaching 4096 with SIZE=1024: fault=1, state_o=2, no further fetches; a redirect to 32'h0 recovers.
REQ-037 SHALL test halt_req pulse then redirect 32'h10: state_o=1 with FIFO draining, then resume at PC 32'h10.
REQ-038 SHALL test rst asserted mid-stream with 2 entries buffered: out_valid=0 immediately (asynchronous), and restart from RESET_PC.
